array_sorted_insert: RTL and testbench

//  Writer-side partner of the sorted-array checker: inserts one value into an ascending array

---
 rtl/array_sorted_insert_if.sv | 33 +++
 rtl/array_sorted_insert.sv | 148 ++++++++++++++
 tb/tb_array_sorted_insert.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/array_sorted_insert_if.sv
`default_nettype none
// ============================================================================
//  Module      : array_sorted_insert_if
//  Description : Command / status / debug-peek bundle for array_sorted_insert.
//                master = requester side, slave = inserter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface array_sorted_insert_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              go;
    logic [ADDR_W-1:0] array;
    logic [ADDR_W-1:0] length;
    logic [WIDTH-1:0]  value;
    logic [ADDR_W-1:0] peek_addr;
    logic [WIDTH-1:0]  peek_data;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W-1:0] pos;

    modport master (
        output go, array, length, value, peek_addr,
        input  peek_data, busy, done, overflow, pos
    );

    modport slave (
        input  go, array, length, value, peek_addr,
        output peek_data, busy, done, overflow, pos
    );
endinterface
`default_nettype wire

// File: rtl/array_sorted_insert.sv
`default_nettype none
// ============================================================================
//  Module      : array_sorted_insert
//  Description : Inserts one value into an ascending array held in an internal
//                register file, shifting larger entries up by one slot, one
//                step per clock, starting from the top of the array.
//  Revision    : 1.0  initial release
// ============================================================================
module array_sorted_insert #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    array_sorted_insert_if.slave  bus
);

    localparam int                c_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r [0:c_DEPTH-1];

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_pos;
    logic [WIDTH-1:0]  r_v;
    logic              r_overflow;

    logic [ADDR_W:0]   w_end;
    logic              w_fits;
    logic [WIDTH-1:0]  w_prev;
    logic              w_at_base;
    logic              w_shift;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WIDTH-1:0]  w_wdata;

    // One extra bit so base+length past the last entry is seen, not wrapped.
    assign w_end     = {1'b0, bus.array} + {1'b0, bus.length};
    assign w_fits    = ~w_end[ADDR_W];

    // Entry just below the slot currently being filled; only meaningful when idx != base.
    assign w_prev    = r[r_idx - c_ONE];
    assign w_at_base = (r_idx == r_base);
    // Strict compare keeps equal values ahead of the new one (stable insert).
    assign w_shift   = !w_at_base && (w_prev > r_v);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and register-file write request (one write per SCAN cycle).
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = r_idx;
        w_wdata     = r_v;
        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_state_nxt = w_fits ? S_SCAN : S_DONE;
                end
            end
            S_SCAN: begin
                w_we = 1'b1;
                if (w_shift) begin
                    w_wdata = w_prev;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.go) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch, scan index walk-down and result capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_base     <= '0;
            r_idx      <= '0;
            r_pos      <= '0;
            r_v        <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_base     <= bus.array;
                        r_v        <= bus.value;
                        r_idx      <= w_end[ADDR_W-1:0];
                        r_overflow <= !w_fits;
                    end
                end
                S_SCAN: begin
                    if (w_shift) begin
                        r_idx <= r_idx - c_ONE;
                    end else begin
                        r_pos <= r_idx;
                    end
                end
                S_DONE: begin
                    if (!bus.go) begin
                        r_overflow <= 1'b0;
                    end
                end
                default: begin
                    r_overflow <= 1'b0;
                end
            endcase
        end
    end

    // Register file: contents survive reset; a reset cycle suppresses the pending write.
    always_ff @(posedge clock) begin
        if (w_we && !reset) begin
            r[w_waddr] <= w_wdata;
        end
    end

    assign bus.peek_data = r[bus.peek_addr];
    assign bus.busy      = (r_state == S_SCAN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.overflow  = r_overflow;
    assign bus.pos       = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_array_sorted_insert.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_sorted_insert
//  Description : Self-checking bench for array_sorted_insert with a queue-based
//                reference model, directed cases and randomized inserts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_array_sorted_insert;

    logic clk = 1'b0;
    logic rst;

    array_sorted_insert_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    array_sorted_insert #(.WIDTH(32), .ADDR_W(5)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference memory image and which entries it actually knows.
    logic [31:0] mem   [0:31];
    bit          known [0:31];

    int ncmp = 0;
    int nbad = 0;

    // Per-cycle expectations maintained by the stimulus, checked by the compare process.
    bit exp_valid = 1'b0;
    bit exp_busy  = 1'b0;
    bit exp_done  = 1'b0;
    bit exp_ovf   = 1'b0;
    int exp_pos   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        ncmp++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Compare process: status every cycle, memory whenever no insert is mid-flight.
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("busy", {63'd0, bus.busy}, {63'd0, exp_busy});
            chk("done", {63'd0, bus.done}, {63'd0, exp_done});
            chk("overflow", {63'd0, bus.overflow}, {63'd0, exp_ovf});
            if (exp_done && !exp_ovf)
                chk("pos", {59'd0, bus.pos}, 64'(exp_pos));
            if (!exp_busy) begin
                int bad;
                if (known[bus.peek_addr])
                    chk("peek_data", {32'd0, bus.peek_data}, {32'd0, mem[bus.peek_addr]});
                bad = 0;
                for (int i = 0; i < 32; i++)
                    if (known[i] && dut.r[i] !== mem[i]) bad++;
                chk("regfile_entries_wrong", 64'(bad), 64'd0);
            end
        end
        bus.peek_addr = 5'($urandom_range(0, 31));
    end

    // Runs one insert; go is held for h cycles after being sampled.
    task automatic do_insert(input int b, input int l, input logic [31:0] v, input int h,
                             output int p, output int scan, output bit ov);
        logic [31:0] q[$];
        int k, d, e;
        ov = (b + l > 31);
        k = 0;
        p = 0;
        if (!ov) begin
            for (int i = 0; i < l; i++) q.push_back(mem[b + i]);
            while (k < l && q[l - 1 - k] > v) k++;
            q.insert(l - k, v);
            p = b + l - k;
        end
        d    = ov ? 0 : k + 1;
        scan = d;
        e    = ((d > h) ? d : h) + 1;

        @(negedge clk);
        bus.go     = 1'b1;
        bus.array  = 5'(b);
        bus.length = 5'(l);
        bus.value  = v;
        for (int j = 0; j <= e; j++) begin
            @(posedge clk);
            #1;
            if (j == h) bus.go = 1'b0;
            // Scramble the latched inputs: they must be ignored after the go sample.
            bus.array  = 5'($urandom);
            bus.length = 5'($urandom);
            bus.value  = $urandom;
            if (j == d && !ov) begin
                for (int i = 0; i <= l; i++) begin
                    mem[b + i]   = q[i];
                    known[b + i] = 1'b1;
                end
            end
            exp_busy = !ov && (j <= k);
            exp_done = (j >= d) && (j < e);
            exp_ovf  = ov && exp_done;
            exp_pos  = p;
        end
    endtask

    task automatic init_all();
        int p, s;
        bit ov;
        for (int i = 0; i < 32; i++)
            do_insert(i, 0, 32'($urandom_range(1, 1000)), 0, p, s, ov);
    endtask

    int          p, s;
    bit          ov;
    logic [31:0] lit [0:5];

    initial begin
        rst        = 1'b1;
        bus.go     = 1'b0;
        bus.array  = '0;
        bus.length = '0;
        bus.value  = '0;
        for (int i = 0; i < 32; i++) known[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_overflow", {63'd0, bus.overflow}, 64'd0);
        chk("reset_pos", {59'd0, bus.pos}, 64'd0);
        rst       = 1'b0;
        exp_valid = 1'b1;

        init_all();

        // Case 1: 1,2,3,5,6 at base 2, insert 4.
        do_insert(2, 0, 1, 0, p, s, ov);
        do_insert(2, 1, 2, 0, p, s, ov);
        do_insert(2, 2, 3, 0, p, s, ov);
        do_insert(2, 3, 5, 0, p, s, ov);
        do_insert(2, 4, 6, 0, p, s, ov);
        do_insert(2, 5, 4, 0, p, s, ov);
        lit = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        for (int i = 0; i < 6; i++) chk("case1_r", {32'd0, dut.r[2 + i]}, {32'd0, lit[i]});
        chk("case1_pos", 64'(p), 64'd5);
        chk("case1_scan_cycles", 64'(s), 64'd3);

        // Case 2: equal values land after existing duplicates.
        do_insert(1, 0, 3, 0, p, s, ov);
        do_insert(1, 1, 3, 0, p, s, ov);
        do_insert(1, 2, 3, 0, p, s, ov);
        do_insert(1, 3, 3, 0, p, s, ov);
        chk("case2_pos", 64'(p), 64'd4);
        chk("case2_scan_cycles", 64'(s), 64'd1);
        for (int i = 1; i <= 4; i++) chk("case2_r", {32'd0, dut.r[i]}, 64'd3);

        // Case 3: empty array.
        do_insert(9, 0, 42, 0, p, s, ov);
        chk("case3_pos", 64'(p), 64'd9);
        chk("case3_scan_cycles", 64'(s), 64'd1);
        chk("case3_r9", {32'd0, dut.r[9]}, 64'd42);

        // Case 4: smallest value goes to the base, neighbour above untouched.
        do_insert(11, 0, 11, 0, p, s, ov);
        do_insert(7, 0, 7, 0, p, s, ov);
        do_insert(7, 1, 8, 0, p, s, ov);
        do_insert(7, 2, 9, 0, p, s, ov);
        do_insert(7, 3, 0, 0, p, s, ov);
        lit = '{32'd0, 32'd7, 32'd8, 32'd9, 32'd11, 32'd0};
        for (int i = 0; i < 5; i++) chk("case4_r", {32'd0, dut.r[7 + i]}, {32'd0, lit[i]});
        chk("case4_pos", 64'(p), 64'd7);

        // Case 5: array would run past the last entry.
        do_insert(28, 0, 100, 0, p, s, ov);
        do_insert(28, 1, 200, 0, p, s, ov);
        do_insert(28, 2, 300, 0, p, s, ov);
        do_insert(28, 3, 400, 0, p, s, ov);
        chk("case4b_no_ovf", {63'd0, ov}, 64'd0);
        do_insert(28, 4, 1, 0, p, s, ov);
        chk("case5_ovf", {63'd0, ov}, 64'd1);
        lit = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) chk("case5_r", {32'd0, dut.r[28 + i]}, {32'd0, lit[i]});

        // Case 6a: go held 20 cycles gives exactly one insert.
        do_insert(20, 0, 77, 20, p, s, ov);
        do_insert(20, 1, 50, 0, p, s, ov);
        chk("case6_r20", {32'd0, dut.r[20]}, 64'd50);
        chk("case6_r21", {32'd0, dut.r[21]}, 64'd77);

        // Case 6b: reset in the middle of a long shift.
        init_all();
        @(negedge clk);
        bus.go     = 1'b1;
        bus.array  = 5'd0;
        bus.length = 5'd20;
        bus.value  = 32'd0;
        @(posedge clk);
        #1;
        bus.go    = 1'b0;
        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midscan_busy", {63'd0, bus.busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("after_reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("after_reset_done", {63'd0, bus.done}, 64'd0);
        for (int i = 0; i <= 20; i++) known[i] = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_ovf   = 1'b0;
        exp_valid = 1'b1;
        init_all();
        do_insert(3, 6, 500, 0, p, s, ov);

        // Randomized inserts, including overflowing and unsorted arrays.
        for (int n = 0; n < 60; n++) begin
            int b, l, h;
            l = $urandom_range(0, 31);
            if ($urandom_range(0, 4) == 0) b = $urandom_range(0, 31);
            else                           b = $urandom_range(0, 31 - l);
            h = $urandom_range(0, 3);
            do_insert(b, l, 32'($urandom_range(0, 1000)), h, p, s, ov);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
`default_nettype wire
